// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - state encoding and divisor helper for tick_generator
package tick_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    // A divisor of zero has no meaning for the counter, so it is promoted to 1.
    function automatic logic [31:0] sanitize_div(input logic [31:0] value);
        return (value == 32'd0) ? 32'd1 : value;
    endfunction

endpackage

// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - programmable clock-enable tick and 50% div_clk with
// boundary-aligned divisor reload through a load/ack handshake
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_value,
    input  logic             div_load,
    output logic             div_ack,
    output logic             tick,
    output logic             div_clk,
    output logic             busy
);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_shadow;
    logic             r_tick;
    logic             r_div_clk;
    logic             r_ack;
    logic             r_busy;

    state_t           w_next_state;
    logic [WIDTH-1:0] w_req;
    logic             w_term;
    logic             w_running;

    assign w_req     = WIDTH'(sanitize_div(32'(div_value)));
    assign w_running = (r_state != ST_IDLE);
    assign w_term    = (r_count == (r_divisor - WIDTH'(1)));

    always_comb begin
        w_next_state = r_state;
        if (!w_running) begin
            if (enable) w_next_state = ST_RUN;
        end else if (!enable) begin
            w_next_state = ST_IDLE;
        end else if (div_load) begin
            w_next_state = ST_PENDING;
        end else begin
            w_next_state = (r_state == ST_PENDING && !w_term) ? ST_PENDING : ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_divisor <= WIDTH'(DEFAULT_DIV);
            r_shadow  <= '0;
            r_tick    <= 1'b0;
            r_div_clk <= 1'b0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == ST_PENDING);
            r_tick  <= 1'b0;
            r_ack   <= 1'b0;
            if (!w_running || !enable) begin
                r_count <= '0;
                // Stopping never leaves a load dangling: a fresh request wins,
                // otherwise any shadow value is committed right away.
                if (div_load) begin
                    r_divisor <= w_req;
                    r_ack     <= 1'b1;
                end else if (r_state == ST_PENDING) begin
                    r_divisor <= r_shadow;
                    r_ack     <= 1'b1;
                end
            end else begin
                if (w_term) begin
                    r_count   <= '0;
                    r_tick    <= 1'b1;
                    r_div_clk <= ~r_div_clk;
                end else begin
                    r_count <= r_count + WIDTH'(1);
                end
                if (r_state == ST_PENDING && w_term) begin
                    r_divisor <= r_shadow;
                    r_ack     <= 1'b1;
                end
                if (div_load) r_shadow <= w_req;
            end
        end
    end

    assign tick    = r_tick;
    assign div_clk = r_div_clk;
    assign div_ack = r_ack;
    assign busy    = r_busy;

endmodule

// File: tb/tb_tick_generator.sv
// tb/tb_tick_generator.sv - table-driven self-checking bench for tick_generator
module tb_tick_generator;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         div_load;
    logic [W-1:0] div_value;
    logic         div_ack;
    logic         tick;
    logic         div_clk;
    logic         busy;

    always #5 clk = ~clk;

    tick_generator #(.WIDTH(W), .DEFAULT_DIV(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .div_value (div_value),
        .div_load  (div_load),
        .div_ack   (div_ack),
        .tick      (tick),
        .div_clk   (div_clk),
        .busy      (busy)
    );

    // ctl = {enable, div_load}; exp = {tick, div_clk, div_ack, busy} after the edge
    typedef struct {
        int           tid;
        logic [1:0]   ctl;
        logic [W-1:0] val;
        logic [3:0]   exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input int tid, input logic [1:0] ctl, input logic [W-1:0] val,
                       input logic [3:0] exp);
        vec_t v;
        v.tid = tid;
        v.ctl = ctl;
        v.val = val;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] exp);
        logic [3:0] got;
        got = {tick, div_clk, div_ack, busy};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: tick/div_clk/ack/busy got %b expected %b",
                     name, idx, got, exp);
        end
    endtask

    initial begin
        logic [3:0] post [4];
        post = '{4'b0000, 4'b0000, 4'b1100, 4'b0100};

        // Test 2: default N=2, steps 0..20
        add(2, 2'b10, 16'd0, 4'b0000);
        for (int k = 1; k <= 20; k++)
            add(2, 2'b10, 16'd0, {(k % 2 == 0), ((k / 2) % 2 == 1), 2'b00});
        // Test 3: load 5 mid-period, steps 21..37
        add(3, 2'b11, 16'd5, 4'b0001);
        add(3, 2'b10, 16'd0, 4'b1110);
        for (int k = 23; k <= 37; k++)
            add(3, 2'b10, 16'd0, {((k - 22) % 5 == 0), (((k - 22) / 5) % 2 == 0), 2'b00});
        // Test 4: stop, load 0 while idle, run at N=1, steps 38..47
        add(4, 2'b00, 16'd0, 4'b0000);
        add(4, 2'b01, 16'd0, 4'b0010);
        add(4, 2'b00, 16'd0, 4'b0000);
        add(4, 2'b10, 16'd0, 4'b0000);
        for (int k = 42; k <= 47; k++)
            add(4, 2'b10, 16'd0, {1'b1, ((k - 41) % 2 == 1), 2'b00});
        // Test 5: N=4, then loads 3 and 7 while pending, steps 48..68
        add(5, 2'b00, 16'd0, 4'b0000);
        add(5, 2'b01, 16'd4, 4'b0010);
        add(5, 2'b10, 16'd0, 4'b0000);
        add(5, 2'b10, 16'd0, 4'b0000);
        add(5, 2'b11, 16'd3, 4'b0001);
        add(5, 2'b11, 16'd7, 4'b0001);
        add(5, 2'b10, 16'd0, 4'b1110);
        for (int k = 55; k <= 68; k++)
            add(5, 2'b10, 16'd0, {((k - 54) % 7 == 0), (((k - 54) / 7) % 2 == 0), 2'b00});
        // Test 6: disable while pending applies 9, then load at RUN terminal, steps 69..89
        add(6, 2'b11, 16'd9, 4'b0101);
        add(6, 2'b00, 16'd0, 4'b0110);
        add(6, 2'b10, 16'd0, 4'b0100);
        for (int k = 72; k <= 80; k++)
            add(6, 2'b10, 16'd0, {(k == 80), (k != 80), 2'b00});
        for (int k = 81; k <= 88; k++)
            add(6, 2'b10, 16'd0, 4'b0000);
        add(6, 2'b11, 16'd5, 4'b1101);

        // Test 1: reset held with enable high
        reset     = 1'b0;
        enable    = 1'b1;
        div_load  = 1'b0;
        div_value = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", i, 4'b0000);
        end
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            enable    = vecs[i].ctl[1];
            div_load  = vecs[i].ctl[0];
            div_value = vecs[i].val;
            @(posedge clk);
            #1;
            check($sformatf("test%0d", vecs[i].tid), i, vecs[i].exp);
        end

        // Asynchronous reset mid-cycle while pending with tick and div_clk high
        div_load  = 1'b0;
        div_value = '0;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 0, 4'b0000);
        @(posedge clk);
        #1;
        check("reset_held", 0, 4'b0000);
        reset = 1'b1;
        // Divisor must be back to 2 and the shadow 5 must never be acked
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("post_reset", i, post[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
